// File: rtl/pulse_stretcher.sv
// Pulse stretcher: every sampled `in` strobe becomes a HIGH_LEN-cycle high window
// followed by a GAP_LEN-cycle forced-low gap. Events that arrive while a window or
// gap is running are counted and served later, in order. When the queue is full,
// further events are dropped and `overflow` strobes for one cycle per drop.
// `out`, `busy` and `overflow` are registered, so they follow the internal state by
// one clock edge. `pending` is the queue counter itself and has no extra delay.
module pulse_stretcher #(
  parameter int unsigned HIGH_LEN = 4,  // 1..255
  parameter int unsigned GAP_LEN  = 2,  // 1..255
  parameter int unsigned MAX_PEND = 3,  // 1..(2**PEND_W - 1)
  parameter int unsigned PEND_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // Reload values for the window/gap down-counter (terminal count is zero)
  localparam logic [7:0]        HighInit = 8'(HIGH_LEN - 1);
  localparam logic [7:0]        GapInit  = 8'(GAP_LEN - 1);
  localparam logic [PEND_W-1:0] MaxPend  = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] PendOne  = PEND_W'(1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StGap  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              out_q, busy_q, ovf_q;
  logic              ovf_d;
  logic              gap_end;

  // The last gap cycle is the only point at which an event can be consumed directly
  assign gap_end = (state_q == StGap) && (cnt_q == 8'd0);

  // Next-state, counter and queue bookkeeping
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Events in IDLE start a window at once and never touch the queue
        if (in) begin
          state_d = StHigh;
          cnt_d   = HighInit;
        end
      end

      StHigh: begin
        if (cnt_q == 8'd0) begin
          state_d = StGap;
          cnt_d   = GapInit;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      StGap: begin
        if (cnt_q == 8'd0) begin
          if (pend_q != '0) begin
            // Serve the oldest queued event; a simultaneous new event takes its
            // place in the queue, so the count only drops when `in` is low
            state_d = StHigh;
            cnt_d   = HighInit;
            if (!in) begin
              pend_d = pend_q - PendOne;
            end
          end else if (in) begin
            // Empty queue: the new event goes straight to a window, no idle cycle
            state_d = StHigh;
            cnt_d   = HighInit;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    // Events not consumed above are queued, or dropped once the queue is full
    if (in && (state_q != StIdle) && !gap_end) begin
      if (pend_q < MaxPend) begin
        pend_d = pend_q + PendOne;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // State, counters and registered outputs; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      pend_q  <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      out_q   <= (state_q == StHigh);
      busy_q  <= (state_q != StIdle);
      ovf_q   <= ovf_d;
    end
  end

  assign out      = out_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher at default parameters. Inputs change and
// outputs are sampled on the falling clock edge; "edge e" is the e-th rising edge
// of a scenario, and every expected value below is written in terms of e.
module tb_pulse_stretcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       out, busy, overflow;
  logic [1:0] pending;

  int vectors = 0;
  int miscompares = 0;

  pulse_stretcher #(
    .HIGH_LEN(4),
    .GAP_LEN (2),
    .MAX_PEND(3),
    .PEND_W  (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drive `in` for one rising edge, then return at the following falling edge
  task automatic step(input logic v);
    in = v;
    @(negedge clk);
  endtask

  task automatic do_reset();
    in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reset values, and `in` ignored while reset is held
  task automatic test_reset();
    logic [4:0] got;
    reset = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step(1'b1);
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_hold e=%0d got out/busy/pend/ovf=%b want %b", e, got, 5'b0);
      end
    end
    reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      step(1'b0);
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_idle e=%0d got out/busy/pend/ovf=%b want %b", e, got, 5'b0);
      end
    end
  endtask

  // One event at edge 0: out high after 1..4, busy after 1..6
  task automatic test_single();
    logic [4:0] got, exp;
    do_reset();
    for (int e = 0; e < 10; e++) begin
      step(e == 0);
      exp = {(e >= 1 && e <= 4), (e >= 1 && e <= 6), 2'd0, 1'b0};
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL single e=%0d got out/busy/pend/ovf=%b want %b", e, got, exp);
      end
    end
  endtask

  // Events at edges 0,1,2: three windows, queue drains at gap ends (edges 6, 12)
  task automatic test_queue();
    logic [4:0] got, exp;
    logic [1:0] p;
    logic       o;
    do_reset();
    for (int e = 0; e < 21; e++) begin
      step(e <= 2);
      if (e == 0) p = 2'd0;
      else if (e == 1) p = 2'd1;
      else if (e < 6) p = 2'd2;
      else if (e < 12) p = 2'd1;
      else p = 2'd0;
      o = (e >= 1 && e <= 4) || (e >= 7 && e <= 10) || (e >= 13 && e <= 16);
      exp = {o, (e >= 1 && e <= 18), p, 1'b0};
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL queue e=%0d got out/busy/pend/ovf=%b want %b", e, got, exp);
      end
    end
  endtask

  // Events at edges 0..5: queue saturates at 3, edges 4 and 5 dropped, 4 windows
  task automatic test_overflow();
    logic [4:0] got, exp;
    logic [1:0] p;
    logic       o;
    do_reset();
    for (int e = 0; e < 28; e++) begin
      step(e <= 5);
      if (e == 0) p = 2'd0;
      else if (e == 1) p = 2'd1;
      else if (e == 2) p = 2'd2;
      else if (e < 6) p = 2'd3;
      else if (e < 12) p = 2'd2;
      else if (e < 18) p = 2'd1;
      else p = 2'd0;
      o = (e >= 1 && e <= 4) || (e >= 7 && e <= 10) || (e >= 13 && e <= 16) ||
          (e >= 19 && e <= 22);
      exp = {o, (e >= 1 && e <= 24), p, (e == 4 || e == 5)};
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL overflow e=%0d got out/busy/pend/ovf=%b want %b", e, got, exp);
      end
    end
  endtask

  // Event at edge 0, then one on the final gap edge 6: back-to-back windows
  task automatic test_back_to_back();
    logic [4:0] got, exp;
    logic       o;
    do_reset();
    for (int e = 0; e < 15; e++) begin
      step(e == 0 || e == 6);
      o = (e >= 1 && e <= 4) || (e >= 7 && e <= 10);
      exp = {o, (e >= 1 && e <= 12), 2'd0, 1'b0};
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL back_to_back e=%0d got out/busy/pend/ovf=%b want %b", e, got, exp);
      end
    end
  endtask

  // Reset mid-window with two queued events clears outputs without a clock edge
  task automatic test_async_reset();
    logic [4:0] got;
    do_reset();
    step(1'b1);
    step(1'b1);
    step(1'b1);
    got = {out, busy, pending, overflow};
    vectors++;
    if (got !== 5'b11100) begin
      miscompares++;
      $display("FAIL async_pre got out/busy/pend/ovf=%b want %b", got, 5'b11100);
    end
    in = 1'b0;
    #2 reset = 1'b1;
    #1;
    got = {out, busy, pending, overflow};
    vectors++;
    if (got !== 5'b0) begin
      miscompares++;
      $display("FAIL async_now got out/busy/pend/ovf=%b want %b", got, 5'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step(1'b0);
      got = {out, busy, pending, overflow};
      vectors++;
      if (got !== 5'b0) begin
        miscompares++;
        $display("FAIL async_after e=%0d got out/busy/pend/ovf=%b want %b", e, got, 5'b0);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_queue();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
